// File: rtl/time_set_ctrl.sv
// Key synchroniser/debouncer and hour/minute set FSM for the HH:MM:SS clock.
// oDbgState encoding: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int BLINK_HALF      = 12_500_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iKeyMode,
  input  logic       iKeyInc,
  input  logic [5:0] iHour,
  input  logic [5:0] iMinute,
  output logic [5:0] oHour,
  output logic [5:0] oMinute,
  output logic       oLoad,
  output logic       oRunEn,
  output logic       oBlankHour,
  output logic       oBlankMin,
  output logic [1:0] oDbgState
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

  // Key index 0 = mode, 1 = inc. Keys are active-low, so 1 means released.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic [1:0]    fall;

  logic [RW-1:0] hold_q, hold_d;
  logic          rpt;
  logic          mode_press, inc_evt;

  state_e        state_q, state_d;
  logic [5:0]    hour_q, hour_d, min_q, min_d;
  logic          load_q, load_d;
  logic          run_en_q, run_en_d;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {iKeyInc, iKeyMode};
      sync2_q <= sync1_q;
    end
  end

  // The press pulse is taken from the flip itself so the FSM acts on the
  // same edge that the debounced level changes.
  always_comb begin
    deb_d = deb_q;
    fall  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (db_cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[k] = sync2_q[k];
          fall[k]  = deb_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      deb_q       <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      deb_q       <= deb_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // After the first repeat the counter is rewound so later repeats come
  // every REPEAT_RATE cycles instead of every REPEAT_DELAY.
  always_comb begin
    hold_d = '0;
    rpt    = 1'b0;
    if (!deb_q[1]) begin
      if (hold_q == RW'(REPEAT_DELAY - 1)) begin
        rpt    = 1'b1;
        hold_d = RW'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  assign mode_press = fall[0];
  assign inc_evt    = fall[1] | rpt;

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    load_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d = SET_HOUR;
          hour_d  = (iHour > 6'd23) ? 6'd0 : iHour;
          min_d   = (iMinute > 6'd59) ? 6'd0 : iMinute;
        end
      end
      SET_HOUR: begin
        if (mode_press) begin
          state_d = SET_MIN;
        end else if (inc_evt) begin
          hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
        end
      end
      SET_MIN: begin
        if (mode_press) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (inc_evt) begin
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: state_d = RUN;
    endcase
    run_en_d = (state_d == RUN);
  end

  // Any accepted key event restarts the blink so the edited field is visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_q == RUN || mode_press || inc_evt) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      hold_q      <= '0;
      state_q     <= RUN;
      hour_q      <= 6'd0;
      min_q       <= 6'd0;
      load_q      <= 1'b0;
      run_en_q    <= 1'b1;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      load_q      <= load_d;
      run_en_q    <= run_en_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign oHour      = hour_q;
  assign oMinute    = min_q;
  assign oLoad      = load_q;
  assign oRunEn     = run_en_q;
  assign oBlankHour = (state_q == SET_HOUR) && phase_q;
  assign oBlankMin  = (state_q == SET_MIN) && phase_q;
  assign oDbgState  = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: edited-value and load events are checked
// by a negedge monitor against expected queues; timing checks are inline.
module tb_time_set_ctrl;

  localparam int ST_RUN = 0;
  localparam int ST_SH  = 1;
  localparam int ST_SM  = 2;

  logic       clk;
  logic       rst_n;
  logic       key_mode, key_inc;
  logic [5:0] hour_in, min_in;
  logic [5:0] hour_out, min_out;
  logic       load, run_en, blank_hour, blank_min;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] edit_q[$];
  logic [11:0] load_exp_q[$];
  logic [11:0] prev_edit;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (5),
    .BLINK_HALF     (8)
  ) dut (
    .iClk      (clk),
    .iRst      (rst_n),
    .iKeyMode  (key_mode),
    .iKeyInc   (key_inc),
    .iHour     (hour_in),
    .iMinute   (min_in),
    .oHour     (hour_out),
    .oMinute   (min_out),
    .oLoad     (load),
    .oRunEn    (run_en),
    .oBlankHour(blank_hour),
    .oBlankMin (blank_min),
    .oDbgState (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic set_key(input int idx, input logic lvl);
    if (idx == 0) key_mode = lvl;
    else key_inc = lvl;
  endtask

  task automatic tap(input int idx);
    set_key(idx, 1'b0);
    tick(6);
    set_key(idx, 1'b1);
    tick(8);
  endtask

  task automatic push_edit(input int h, input int m);
    edit_q.push_back({h[5:0], m[5:0]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, dbg_state, ST_RUN);
    check({tag, "_hour"}, hour_out, 0);
    check({tag, "_min"}, min_out, 0);
    check({tag, "_load"}, load, 0);
    check({tag, "_run_en"}, run_en, 1);
    check({tag, "_blank_h"}, blank_hour, 0);
    check({tag, "_blank_m"}, blank_min, 0);
  endtask

  // Scoreboard monitor: every change of the edited value and every load
  // cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_edit = {hour_out, min_out};
    end else begin
      if ({hour_out, min_out} != prev_edit) begin
        if (edit_q.size() == 0) begin
          check("edit_unexpected", int'({hour_out, min_out}), int'(prev_edit));
        end else begin
          check("edit_value", int'({hour_out, min_out}), int'(edit_q.pop_front()));
        end
        prev_edit = {hour_out, min_out};
      end
      if (load) begin
        if (load_exp_q.size() == 0) check("load_unexpected", 1, 0);
        else check("load_value", int'({hour_out, min_out}), int'(load_exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    key_mode = 1'b1;
    key_inc  = 1'b1;
    hour_in  = 6'd22;
    min_in   = 6'd58;
    tick(3);
    check_reset_outputs("rst_low");
    rst_n = 1'b1;
    tick(3);
    check_reset_outputs("rst_done");

    // 1: short glitches are ignored, then a stable press enters SET_HOUR
    for (int g = 0; g < 3; g++) begin
      key_mode = 1'b0;
      tick(3);
      key_mode = 1'b1;
      tick(3);
    end
    tick(4);
    check("glitch_state", dbg_state, ST_RUN);
    check("glitch_run_en", run_en, 1);
    push_edit(22, 58);
    key_mode = 1'b0;
    tick(5);
    check("press_early_state", dbg_state, ST_RUN);
    check("press_early_run_en", run_en, 1);
    tick(1);
    check("press_state", dbg_state, ST_SH);
    check("press_run_en", run_en, 0);
    key_mode = 1'b1;
    tick(8);

    // 2: hour wraps 23->0, minute wraps 59->0, load strobe
    push_edit(23, 58);
    tap(1);
    push_edit(0, 58);
    tap(1);
    tap(0);
    check("t2_state_min", dbg_state, ST_SM);
    push_edit(0, 59);
    tap(1);
    push_edit(0, 0);
    tap(1);
    push_edit(0, 1);
    tap(1);
    load_exp_q.push_back({6'd0, 6'd1});
    tap(0);
    check("t2_state_run", dbg_state, ST_RUN);
    check("t2_run_en", run_en, 1);
    check("t2_load_seen", load_exp_q.size(), 0);

    // 3: auto-repeat in SET_MIN
    push_edit(22, 58);
    tap(0);
    tap(0);
    check("t3_state", dbg_state, ST_SM);
    push_edit(22, 59);
    push_edit(22, 0);
    push_edit(22, 1);
    push_edit(22, 2);
    push_edit(22, 3);
    key_inc = 1'b0;
    tick(36);
    key_inc = 1'b1;
    tick(20);
    check("t3_repeats_done", edit_q.size(), 0);
    check("t3_min", min_out, 3);
    load_exp_q.push_back({6'd22, 6'd3});
    tap(0);
    check("t3_state_run", dbg_state, ST_RUN);

    // 4: blink in SET_HOUR, inc press restarts the visible half
    hour_in = 6'd5;
    min_in  = 6'd10;
    push_edit(5, 10);
    key_mode = 1'b0;
    tick(6);
    check("t4_state", dbg_state, ST_SH);
    for (int j = 0; j < 46; j++) begin
      int exp_blank;
      exp_blank = (j < 37) ? ((j / 8) % 2) : ((j >= 45) ? 1 : 0);
      check($sformatf("t4_blank_h_%0d", j), blank_hour, exp_blank);
      check($sformatf("t4_blank_m_%0d", j), blank_min, 0);
      if (j == 2) key_mode = 1'b1;
      if (j == 31) begin
        push_edit(6, 10);
        key_inc = 1'b0;
      end
      if (j == 39) key_inc = 1'b1;
      tick(1);
    end

    // 5: simultaneous mode and inc press: mode wins
    tick(4);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    tick(5);
    check("t5_early_state", dbg_state, ST_SH);
    tick(1);
    check("t5_state", dbg_state, ST_SM);
    check("t5_hour", hour_out, 6);
    check("t5_min", min_out, 10);
    key_mode = 1'b1;
    key_inc  = 1'b1;
    tick(8);

    // 6: reset mid-edit, then out-of-range hour captured as 0
    push_edit(6, 11);
    tap(1);
    check("t6_min_before_rst", min_out, 11);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("t6_rst");
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check_reset_outputs("t6_after");
    hour_in = 6'd30;
    min_in  = 6'd45;
    push_edit(0, 45);
    tap(0);
    check("t6_state", dbg_state, ST_SH);
    check("t6_hour", hour_out, 0);
    check("t6_min", min_out, 45);

    tick(2);
    check("final_edit_q", edit_q.size(), 0);
    check("final_load_q", load_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Input-side companion to the HH:MM:SS display path. Takes the two raw board keys, synchronises and debounces them, and runs a mode FSM that lets the user set hours and minutes. The new time is written back into the hour/minute counters with a one-cycle load strobe, and the seconds prescaler is paused while setting. Blank controls are provided so the field being edited blinks on the seven-segment digits.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz).
REPEAT_DELAY, 25_000_000, hold time after a press before auto-repeat starts.
REPEAT_RATE, 5_000_000, interval between auto-repeat increments.
BLINK_HALF, 12_500_000, half-period of the edit-field blink.

Ports:
iClk  in  1  system clock.
iRst  in  1  asynchronous reset, active-low.
iKeyMode  in  1  raw mode key, active-low, asynchronous to iClk.
iKeyInc  in  1  raw increment key, active-low, asynchronous to iClk.
iHour  in  6  current hour from the running counter, 0..23.
iMinute  in  6  current minute from the running counter, 0..59.
oHour  out  6  edited hour (shadow register).
oMinute  out  6  edited minute (shadow register).
oLoad  out  1  one-cycle strobe; counters load oHour/oMinute and clear seconds.
oRunEn  out  1  1 = seconds prescaler may run.
oBlankHour  out  1  1 = blank the hour digits this cycle.
oBlankMin  out  1  1 = blank the minute digits this cycle.

Behaviour:
- Reset values:
  - FSM = RUN.
  - oHour = oMinute = 0.
  - oLoad = 0, oRunEn = 1, oBlankHour = oBlankMin = 0.
  - Synchroniser flops and debounced levels = 1 (released).
  - All counters = 0.
- Sync: two-flop synchroniser per key.
- Debounce: per key, the counter increments while the synced value differs from the debounced level and clears when it matches. When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- Press event: one-cycle pulse on a 1->0 transition of the debounced level. Latency from a stable raw edge to the press pulse is 2 + DEBOUNCE_CYCLES cycles.
- Auto-repeat (inc key only, SET states only):
  - While debounced inc = 0, the hold counter runs.
  - The first repeat pulse fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_RATE cycles.
  - Release clears the hold counter.
  - incEvt = press pulse OR repeat pulse.
- FSM states and transitions:
  - RUN: on mode press, go to SET_HOUR. In the same cycle, capture iHour into oHour and iMinute into oMinute; a captured hour >23 or minute >59 is replaced by 0. incEvt is ignored.
  - SET_HOUR: on mode press, go to SET_MIN. On incEvt, oHour = (oHour==23) ? 0 : oHour+1.
  - SET_MIN: on mode press, go to RUN and assert oLoad for exactly that one cycle. On incEvt, oMinute = (oMinute==59) ? 0 : oMinute+1.
- oRunEn = 1 only in RUN (registered; deasserts on the cycle after the mode press).
- Simultaneous mode press and incEvt in the same cycle: mode wins, the increment is dropped.
- Blink:
  - The phase counter runs only in SET states; phase toggles every BLINK_HALF cycles.
  - Phase and counter are cleared to visible (phase 0) on entering a SET state and on every incEvt.
  - oBlankHour = (state==SET_HOUR) && phase; oBlankMin = (state==SET_MIN) && phase.
- Reset mid-edit: return to RUN, no oLoad, edits discarded, oRunEn = 1.
- A key held across reset deassertion is not a press: the debounced level starts at 1 and must settle, so a press is generated only after release and re-press, or after DEBOUNCE_CYCLES if held.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, BLINK_HALF=8):
1. Reset, then mode key low with 3-cycle glitches (shorter than DEBOUNCE_CYCLES) -> no press, state stays RUN, oRunEn = 1. Stable low -> SET_HOUR entered exactly 6 cycles after the stable edge, oRunEn = 0.
2. iHour=22, iMinute=58; mode press, 2 inc presses, mode press, 3 inc presses, mode press -> oHour 22->23->0, oMinute 58->59->0->1. oLoad is a single 1-cycle pulse with oHour=0 and oMinute=1; oRunEn returns to 1.
3. In SET_MIN, hold inc for 40 cycles after the press -> increments at press, +20, +25, +30, +35: 5 increments total. Release -> no further increments.
4. Blink in SET_HOUR with no key activity -> oBlankHour toggles every 8 cycles and oBlankMin stays 0. An inc press forces oBlankHour = 0 for the next 8 cycles.
5. Mode press and inc press debounced in the same cycle in SET_HOUR -> state becomes SET_MIN, oHour unchanged.
6. Assert iRst in SET_MIN after edits -> all outputs at reset values, no oLoad. iHour=30 captured on entry -> oHour = 0.
